// File: rtl/game_state_ctrl.sv
// game_state_ctrl
// Central game-flow controller for the typing game. Tracks score, lives,
// boss hit-points and the boss countdown from hit/miss events and the frame
// tick, and drives the show flags consumed by the display-line selector.
//
// Ports:
//   clk         system clock
//   clrn        asynchronous active-low reset
//   key_enter   Enter key level, synchronous to clk (edge-detected inside)
//   hit         1-cycle pulse, word typed correctly
//   miss        1-cycle pulse, word reached the bottom / failed
//   frame_tick  1-cycle pulse per displayed frame
//   start_show  1 = game screens active, 0 = start screen
//   boss_show   boss fight in progress
//   win_show    win screen
//   lose_show   lose screen
//   score       current score (saturates at 255)
//   lives       remaining lives
//   boss_hp     remaining boss hit-points
//   boss_time   frame ticks remaining in the boss fight
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | start screen, waiting for Enter
// PLAY  | normal play until score reaches BOSS_SCORE
// BOSS  | boss fight, countdown running on frame_tick
// WIN   | win screen, held for HOLD_FRAMES before restart
// LOSE  | lose screen, held for HOLD_FRAMES before restart
module game_state_ctrl #(
  parameter int LIVES       = 3,
  parameter int BOSS_SCORE  = 20,
  parameter int BOSS_HP     = 10,
  parameter int BOSS_FRAMES = 1800,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_enter,
  input  logic        hit,
  input  logic        miss,
  input  logic        frame_tick,
  output logic        start_show,
  output logic        boss_show,
  output logic        win_show,
  output logic        lose_show,
  output logic [7:0]  score,
  output logic [3:0]  lives,
  output logic [5:0]  boss_hp,
  output logic [11:0] boss_time
);

  localparam logic [3:0]  LIVES_V  = 4'(LIVES);
  localparam logic [7:0]  BSCORE_V = 8'(BOSS_SCORE);
  localparam logic [5:0]  BHP_V    = 6'(BOSS_HP);
  localparam logic [11:0] BTIME_V  = 12'(BOSS_FRAMES);
  localparam logic [11:0] HOLD_V   = 12'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    BOSS = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [7:0]  score_n, score_sat;
  logic [3:0]  lives_n;
  logic [5:0]  boss_hp_n;
  logic [11:0] boss_time_n;
  logic [11:0] hold, hold_n;
  logic        key_enter_q;
  logic        enter_p;
  logic        lose_cond;
  logic        win_cond;

  assign enter_p   = key_enter & ~key_enter_q;
  assign score_sat = (score == 8'hFF) ? score : score + 8'd1;

  always_comb begin
    state_n     = state;
    score_n     = score;
    lives_n     = lives;
    boss_hp_n   = boss_hp;
    boss_time_n = boss_time;
    hold_n      = hold;
    lose_cond   = 1'b0;
    win_cond    = 1'b0;
    case (state)
      IDLE: begin
        if (enter_p) begin
          state_n     = PLAY;
          score_n     = 8'd0;
          lives_n     = LIVES_V;
          boss_hp_n   = BHP_V;
          boss_time_n = BTIME_V;
        end
      end
      PLAY: begin
        if (hit) score_n = score_sat;
        if (miss && lives != 4'd0) lives_n = lives - 4'd1;
        lose_cond = miss && (lives_n == 4'd0);
        win_cond  = hit && (score_n == BSCORE_V);
        if (lose_cond) begin
          state_n = LOSE;
          hold_n  = 12'd0;
        end else if (win_cond) begin
          state_n = BOSS;
        end
      end
      BOSS: begin
        if (hit) begin
          score_n = score_sat;
          if (boss_hp != 6'd0) boss_hp_n = boss_hp - 6'd1;
        end
        if (miss && lives != 4'd0) lives_n = lives - 4'd1;
        if (frame_tick && boss_time != 12'd0) boss_time_n = boss_time - 12'd1;
        // losing takes priority when both outcomes land on the same edge
        lose_cond = (miss && lives_n == 4'd0) || (frame_tick && boss_time_n == 12'd0);
        win_cond  = hit && (boss_hp_n == 6'd0);
        if (lose_cond) begin
          state_n = LOSE;
          hold_n  = 12'd0;
        end else if (win_cond) begin
          state_n = WIN;
          hold_n  = 12'd0;
        end
      end
      WIN, LOSE: begin
        // early Enter is dropped, not queued
        if (enter_p && hold == HOLD_V) begin
          state_n = IDLE;
        end else if (frame_tick && hold != HOLD_V) begin
          hold_n = hold + 12'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      score       <= 8'd0;
      lives       <= LIVES_V;
      boss_hp     <= BHP_V;
      boss_time   <= BTIME_V;
      hold        <= 12'd0;
      key_enter_q <= 1'b0;
    end else begin
      state       <= state_n;
      score       <= score_n;
      lives       <= lives_n;
      boss_hp     <= boss_hp_n;
      boss_time   <= boss_time_n;
      hold        <= hold_n;
      key_enter_q <= key_enter;
    end
  end

  assign start_show = (state != IDLE);
  assign boss_show  = (state == BOSS);
  assign win_show   = (state == WIN);
  assign lose_show  = (state == LOSE);

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  logic        clk;
  logic        clrn;
  logic        key_enter, hit, miss, frame_tick;
  logic        start_show, boss_show, win_show, lose_show;
  logic [7:0]  score;
  logic [3:0]  lives;
  logic [5:0]  boss_hp;
  logic [11:0] boss_time;

  int n_err;
  int n_checks;

  game_state_ctrl dut (
    .clk        (clk),
    .clrn       (clrn),
    .key_enter  (key_enter),
    .hit        (hit),
    .miss       (miss),
    .frame_tick (frame_tick),
    .start_show (start_show),
    .boss_show  (boss_show),
    .win_show   (win_show),
    .lose_show  (lose_show),
    .score      (score),
    .lives      (lives),
    .boss_hp    (boss_hp),
    .boss_time  (boss_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [33:0] dut_vec;
  assign dut_vec = {start_show, boss_show, win_show, lose_show, score, lives, boss_hp, boss_time};

  localparam logic [33:0] RESET_VEC = {4'b0000, 8'd0, 4'd3, 6'd10, 12'd1800};

  // Reference model: game phase as a plain integer, counters as ints.
  // phase: 0 start screen, 1 play, 2 boss, 3 win, 4 lose
  int m_phase, m_score, m_lives, m_hp, m_time, m_hold;
  bit m_prev_enter;

  function automatic logic [33:0] model_vec();
    logic [3:0] sh;
    sh = {m_phase != 0, m_phase == 2, m_phase == 3, m_phase == 4};
    return {sh, 8'(m_score), 4'(m_lives), 6'(m_hp), 12'(m_time)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_lives = 3; m_hp = 10; m_time = 1800;
    m_hold = 0; m_prev_enter = 0;
  endtask

  task automatic model_step(input bit ke, input bit h, input bit m, input bit t);
    bit ev, lost, won;
    ev = ke && !m_prev_enter;
    m_prev_enter = ke;
    lost = 0; won = 0;
    if (m_phase == 0) begin
      if (ev) begin
        m_phase = 1; m_score = 0; m_lives = 3; m_hp = 10; m_time = 1800;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (h) m_score = (m_score < 255) ? m_score + 1 : 255;
      if (m) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        if (m_lives == 0) lost = 1;
      end
      if (m_phase == 1) begin
        if (h && m_score == 20) won = 1;
      end else begin
        if (h) begin
          m_hp = (m_hp > 0) ? m_hp - 1 : 0;
          if (m_hp == 0) won = 1;
        end
        if (t) begin
          m_time = (m_time > 0) ? m_time - 1 : 0;
          if (m_time == 0) lost = 1;
        end
      end
      if (lost) begin
        m_phase = 4; m_hold = 0;
      end else if (won) begin
        m_hold = 0;
        m_phase = (m_phase == 1) ? 2 : 3;
      end
    end else begin
      if (ev && m_hold == 60) m_phase = 0;
      else if (t) m_hold = (m_hold < 60) ? m_hold + 1 : 60;
    end
  endtask

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit ke, input bit h, input bit m, input bit t);
    @(negedge clk);
    key_enter = ke; hit = h; miss = m; frame_tick = t;
    @(posedge clk);
    #1;
    model_step(ke, h, m, t);
    check("model", dut_vec, model_vec());
  endtask

  typedef struct {
    bit ke, h, m, t;
    logic [3:0] show;
    logic [7:0] sc;
    logic [3:0] lv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rke;
    n_err = 0; n_checks = 0;
    tbl[0]  = '{1, 0, 0, 0, 4'b1000, 8'd0, 4'd3};
    tbl[1]  = '{1, 0, 0, 0, 4'b1000, 8'd0, 4'd3};
    tbl[2]  = '{1, 0, 0, 0, 4'b1000, 8'd0, 4'd3};
    tbl[3]  = '{1, 0, 0, 0, 4'b1000, 8'd0, 4'd3};
    tbl[4]  = '{1, 0, 0, 0, 4'b1000, 8'd0, 4'd3};
    tbl[5]  = '{0, 1, 0, 0, 4'b1000, 8'd1, 4'd3};
    tbl[6]  = '{0, 1, 1, 0, 4'b1000, 8'd2, 4'd2};
    tbl[7]  = '{0, 0, 1, 0, 4'b1000, 8'd2, 4'd1};
    tbl[8]  = '{0, 0, 0, 1, 4'b1000, 8'd2, 4'd1};
    tbl[9]  = '{1, 1, 0, 0, 4'b1000, 8'd3, 4'd1};
    tbl[10] = '{0, 0, 1, 0, 4'b1001, 8'd3, 4'd0};
    tbl[11] = '{0, 1, 0, 0, 4'b1001, 8'd3, 4'd0};
    tbl[12] = '{0, 0, 1, 1, 4'b1001, 8'd3, 4'd0};

    clrn = 1'b0; key_enter = 0; hit = 0; miss = 0; frame_tick = 0;
    model_reset();
    #12;
    check("reset_state", dut_vec, RESET_VEC);
    @(negedge clk) clrn = 1'b1;
    cyc(0, 0, 0, 0);

    // Enter held 5 cycles, play misses down to LOSE, frozen counters
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].ke, tbl[i].h, tbl[i].m, tbl[i].t);
      check($sformatf("tbl[%0d]", i),
            34'({start_show, boss_show, win_show, lose_show, score, lives}),
            34'({tbl[i].show, tbl[i].sc, tbl[i].lv}));
    end

    // LOSE hold boundary: one tick short, then exactly HOLD_FRAMES
    repeat (58) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("lose_hold_59", 34'(lose_show), 34'(1));
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("lose_exit", 34'({start_show, boss_show, win_show, lose_show}), 34'(0));

    // 20 hits into BOSS, 10 hits to WIN
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("play_again", 34'(start_show), 34'(1));
    cyc(0, 0, 0, 0);
    repeat (19) cyc(0, 1, 0, 0);
    check("before_boss", 34'({boss_show, score}), 34'({1'b0, 8'd19}));
    cyc(0, 1, 0, 0);
    check("enter_boss", 34'({boss_show, score}), 34'({1'b1, 8'd20}));
    repeat (9) cyc(0, 1, 0, 0);
    check("boss_hp_1", 34'({boss_show, boss_hp}), 34'({1'b1, 6'd1}));
    cyc(0, 1, 0, 0);
    check("win", 34'({boss_show, win_show, score, boss_hp}), 34'({1'b0, 1'b1, 8'd30, 6'd0}));

    // WIN hold: Enter after 30 ticks ignored, after 60 accepted
    repeat (30) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("win_hold_30", 34'(win_show), 34'(1));
    cyc(0, 0, 0, 0);
    repeat (30) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("win_exit", 34'({start_show, boss_show, win_show, lose_show}), 34'(0));

    // boss countdown expiry
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 1, 0, 0);
    repeat (1799) cyc(0, 0, 0, 1);
    check("boss_time_1", 34'({boss_show, boss_time}), 34'({1'b1, 12'd1}));
    cyc(0, 0, 0, 1);
    check("boss_timeout", 34'({lose_show, boss_time}), 34'({1'b1, 12'd0}));
    repeat (3) cyc(0, 0, 0, 1);
    check("boss_time_no_wrap", 34'(boss_time), 34'(0));

    // last life and last boss hp on the same edge
    @(negedge clk) clrn = 1'b0;
    #2;
    model_reset();
    check("reset_pulse", dut_vec, RESET_VEC);
    @(negedge clk) clrn = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0);
    repeat (20) cyc(0, 1, 0, 0);
    repeat (9) cyc(0, 1, 0, 0);
    check("boss_last", 34'({boss_show, lives, boss_hp}), 34'({1'b1, 4'd1, 6'd1}));
    cyc(0, 1, 1, 0);
    check("lose_priority", 34'({win_show, lose_show, lives, boss_hp}),
          34'({1'b0, 1'b1, 4'd0, 6'd0}));

    // async reset between clock edges
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec, RESET_VEC);
    @(negedge clk) clrn = 1'b1;

    // randomized play against the model
    rke = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rke = ~rke;
      cyc(rke, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
